register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   RV32I integer register file: 32 x 32-bit registers, two combinational read ports
//   (rs1, rs2) and one synchronous write port (rd). Sits in the decode/writeback
//   path of the core. x0 is hardwired to zero.
// PARAMETERS
//   DATA_WIDTH  32  register width in bits
//   ADDR_WIDTH  5   register index width; NUM_REGS = 2**ADDR_WIDTH (32)
// PORTS
//   Interface: one clock; reset is synchronous and active-low.
//   clk        in   1           clock; all state updates on rising edge
//   rst        in   1           synchronous reset, active-low (0 = reset)
//   reg_write  in   1           write enable for the rd port
//   rd         in   ADDR_WIDTH  write register index
//   rd_data    in   DATA_WIDTH  write data
//   rs1        in   ADDR_WIDTH  read port 1 index
//   rs2        in   ADDR_WIDTH  read port 2 index
//   rs1_data   out  DATA_WIDTH  read port 1 data
//   rs2_data   out  DATA_WIDTH  read port 2 data
// BEHAVIOUR
//   - Reset: at a rising clk with rst==0, all registers x0..x31 are cleared to 0.
//     Reset takes priority over any write in the same cycle. rst has no
//     effect between clock edges.
//   - Write: at a rising clk with rst==1, reg_write==1, rd!=0: regs[rd] <= rd_data.
//     Registers update one edge after presentation; reg_write==0 leaves all state unchanged.
//   - x0: writes with rd==0 are discarded; reads of index 0 always return 0
//     (forced in the read path, not only by the storage).
//   - Read: rs1_data = regs[rs1], rs2_data = regs[rs2]; purely combinational,
//     zero latency, both ports independent; rs1==rs2 permitted.
//   - After reset, outputs read 0 for all indices without requiring a clock edge
//     beyond the reset edge itself.
//   - Read-during-write (same index, same cycle), default build: read returns the
//     OLD value until the clock edge; new value visible after the edge.
//   - Outputs never X once reset has been applied.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: write-through bypass. If reg_write==1, rst==1,
//     rd!=0 and rsN==rd, rsN_data = rd_data combinationally (same cycle).
//     rsN==0 still returns 0. The bypass also applies to both ports simultaneously.
//   REGFILE_BYPASS_EN undefined: no bypass; old-value semantics as above.
// TESTING
//   1. rst=0 for one edge, then rs1=5, rs2=10 -> rs1_data=0, rs2_data=0.
//   2. reg_write=1, rd=0, rd_data=DEADBEEF, clock; rs1=rs2=0 -> both read 00000000.
//   3. reg_write=1, rd=5, rd_data=CAFEBABE, clock; reg_write=0, rs1=5 -> CAFEBABE.
//   4. Write rd=10 <= 12345678; rs1=10, rs2=5 -> 12345678, CAFEBABE (dual read).
//   5. rst=0 for one edge with reg_write=1, rd=7, rd_data=FFFFFFFF; rs1=5, rs2=7
//      -> both 0 (reset clears and wins over write); rs2=10 -> 0.
//   6. reg_write=1, rd=3, rd_data=A5A5A5A5, rs1=3 before edge -> 0 (bypass off)
//      or A5A5A5A5 (REGFILE_BYPASS_EN); after edge -> A5A5A5A5 in both builds.

Source files
------------

// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file
// Purpose  : RV32I integer register file, 32 x 32-bit, two combinational read
//            ports and one synchronous write port. x0 always reads zero.
//            Macro REGFILE_BYPASS_EN enables same-cycle write-through bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;

    assign w_wr_en = rst && reg_write && (rd != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= rd_data;
        end
    end

    // Index 0 is forced to zero here so x0 never depends on storage contents.
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
`ifdef REGFILE_BYPASS_EN
        if (rs1 != '0) begin
            w_rs1_data = (w_wr_en && (rs1 == rd)) ? rd_data : r_regs[rs1];
        end
        if (rs2 != '0) begin
            w_rs2_data = (w_wr_en && (rs2 == rd)) ? rd_data : r_regs[rs2];
        end
`else
        if (rs1 != '0) begin
            w_rs1_data = r_regs[rs1];
        end
        if (rs2 != '0) begin
            w_rs2_data = r_regs[rs2];
        end
`endif
    end

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module   : tb_register_file
// Purpose  : Directed self-checking bench for register_file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int vectors;
    int miscompares;

    register_file #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .reg_write (reg_write),
        .rd        (rd),
        .rd_data   (rd_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; reg_write = 1'b0; rd = '0; rd_data = '0; rs1 = '0; rs2 = '0;
        tick();
        rst = 1'b1;
        rs1 = 5'd5; rs2 = 5'd10;
        #1;
        vectors++;
        if (rs1_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rs1: got %h expected %h", rs1_data, 32'h0);
        end
        vectors++;
        if (rs2_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rs2: got %h expected %h", rs2_data, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            rs1 = i[4:0]; rs2 = 5'(31 - i);
            #1;
            vectors++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_all[%0d]: got %h/%h expected 0/0", i, rs1_data, rs2_data);
            end
        end
    endtask

    task automatic test_x0();
        reg_write = 1'b1; rd = 5'd0; rd_data = 32'hDEADBEEF;
        rs1 = 5'd0; rs2 = 5'd0;
        tick();
        reg_write = 1'b0;
        #1;
        vectors++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_write: got %h/%h expected 00000000/00000000", rs1_data, rs2_data);
        end
    endtask

    task automatic test_write_read();
        reg_write = 1'b1; rd = 5'd5; rd_data = 32'hCAFEBABE;
        tick();
        reg_write = 1'b0; rs1 = 5'd5;
        #1;
        vectors++;
        if (rs1_data !== 32'hCAFEBABE) begin
            miscompares++;
            $display("FAIL write_read: got %h expected %h", rs1_data, 32'hCAFEBABE);
        end
        // Disabled write must not alter state.
        reg_write = 1'b0; rd = 5'd5; rd_data = 32'h11111111;
        tick();
        vectors++;
        if (rs1_data !== 32'hCAFEBABE) begin
            miscompares++;
            $display("FAIL write_disabled: got %h expected %h", rs1_data, 32'hCAFEBABE);
        end
    endtask

    task automatic test_dual_read();
        reg_write = 1'b1; rd = 5'd10; rd_data = 32'h12345678;
        tick();
        reg_write = 1'b0; rs1 = 5'd10; rs2 = 5'd5;
        #1;
        vectors++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'hCAFEBABE) begin
            miscompares++;
            $display("FAIL dual_read: got %h/%h expected 12345678/cafebabe", rs1_data, rs2_data);
        end
        rs1 = 5'd5; rs2 = 5'd5;
        #1;
        vectors++;
        if (rs1_data !== 32'hCAFEBABE || rs2_data !== 32'hCAFEBABE) begin
            miscompares++;
            $display("FAIL same_index: got %h/%h expected cafebabe/cafebabe", rs1_data, rs2_data);
        end
    endtask

    task automatic test_reset_async_ignored();
        rs1 = 5'd5;
        rst = 1'b0;
        #2;
        vectors++;
        if (rs1_data !== 32'hCAFEBABE) begin
            miscompares++;
            $display("FAIL rst_between_edges: got %h expected %h", rs1_data, 32'hCAFEBABE);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (rs1_data !== 32'hCAFEBABE) begin
            miscompares++;
            $display("FAIL rst_glitch_kept: got %h expected %h", rs1_data, 32'hCAFEBABE);
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b0; reg_write = 1'b1; rd = 5'd7; rd_data = 32'hFFFFFFFF;
        tick();
        rst = 1'b1; reg_write = 1'b0; rs1 = 5'd5; rs2 = 5'd7;
        #1;
        vectors++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_priority: got %h/%h expected 0/0", rs1_data, rs2_data);
        end
        rs2 = 5'd10;
        #1;
        vectors++;
        if (rs2_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_clears_x10: got %h expected %h", rs2_data, 32'h0);
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] exp_before;
`ifdef REGFILE_BYPASS_EN
        exp_before = 32'hA5A5A5A5;
`else
        exp_before = 32'h0;
`endif
        reg_write = 1'b1; rd = 5'd3; rd_data = 32'hA5A5A5A5; rs1 = 5'd3; rs2 = 5'd3;
        #1;
        vectors++;
        if (rs1_data !== exp_before || rs2_data !== exp_before) begin
            miscompares++;
            $display("FAIL rdw_before_edge: got %h/%h expected %h/%h", rs1_data, rs2_data, exp_before, exp_before);
        end
        rs2 = 5'd0;
        #1;
        vectors++;
        if (rs2_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rdw_x0_port: got %h expected %h", rs2_data, 32'h0);
        end
        tick();
        reg_write = 1'b0;
        #1;
        vectors++;
        if (rs1_data !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL rdw_after_edge: got %h expected %h", rs1_data, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 32; i++) begin
            reg_write = 1'b1; rd = i[4:0];
            rd_data = (32'(i) * 32'h01010101) ^ 32'h5A000000;
            tick();
        end
        reg_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp1;
            logic [31:0] exp2;
            int j;
            j = 31 - i;
            exp1 = (i == 0) ? 32'h0 : ((32'(i) * 32'h01010101) ^ 32'h5A000000);
            exp2 = (j == 0) ? 32'h0 : ((32'(j) * 32'h01010101) ^ 32'h5A000000);
            rs1 = i[4:0]; rs2 = j[4:0];
            #1;
            vectors++;
            if (rs1_data !== exp1 || rs2_data !== exp2) begin
                miscompares++;
                $display("FAIL b2b_read[%0d]: got %h/%h expected %h/%h", i, rs1_data, rs2_data, exp1, exp2);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; reg_write = 1'b0; rd = '0; rd_data = '0; rs1 = '0; rs2 = '0;
        tick();
        test_reset();
        test_x0();
        test_write_read();
        test_dual_read();
        test_reset_async_ignored();
        test_reset_priority();
        test_read_during_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
